// File: rtl/bsg_manycore_block_mem_bank.sv
// Single-port block-memory bank: byte-masked stores, sign/zero-extended sub-word loads, block-id
// filtering. Defining BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN adds a power-on scrub to zero.
module bsg_manycore_block_mem_bank #(
  parameter int unsigned data_width_p        = 32,
  parameter int unsigned mem_size_in_words_p = 512,
  parameter int unsigned num_tiles_x_p       = 4,
  localparam int unsigned mem_addr_width_lp  =
    ((mem_size_in_words_p == 1) ? 1 : $clog2(mem_size_in_words_p)) + 2,
  localparam int unsigned num_blocks_lp      = 2 * num_tiles_x_p,
  localparam int unsigned block_id_width_lp  =
    (num_blocks_lp == 1) ? 1 : $clog2(num_blocks_lp),
  localparam int unsigned block_words_lp     = mem_size_in_words_p / num_blocks_lp,
  localparam int unsigned word_addr_width_lp =
    (block_words_lp == 1) ? 1 : $clog2(block_words_lp),
  localparam int unsigned pkt_width_lp       =
    3 + mem_addr_width_lp + data_width_p + data_width_p / 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [pkt_width_lp-1:0]      pkt_i,
  input  logic                         v_i,
  input  logic [block_id_width_lp-1:0] block_id_i,
  output logic [data_width_p-1:0]      data_o,
  output logic                         err_o,
  output logic                         busy_o
);

  // Packet layout, MSB first: {opcode[2:0], addr, data, mask}.
  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpLw    = 3'd1;
  localparam logic [2:0] OpLb    = 3'd2;
  localparam logic [2:0] OpLbu   = 3'd3;
  localparam logic [2:0] OpLh    = 3'd4;
  localparam logic [2:0] OpLhu   = 3'd5;
  localparam logic [2:0] OpStore = 3'd6;

  logic [2:0]                    pkt_op;
  logic [mem_addr_width_lp-1:0]  pkt_addr;
  logic [data_width_p-1:0]       pkt_data;
  logic [data_width_p/8-1:0]     pkt_mask;

  assign {pkt_op, pkt_addr, pkt_data, pkt_mask} = pkt_i;

  logic [1:0]                    pkt_off;
  logic [word_addr_width_lp-1:0] pkt_idx;
  logic [block_id_width_lp-1:0]  pkt_id;

  assign pkt_off = pkt_addr[1:0];
  assign pkt_idx = pkt_addr[2 +: word_addr_width_lp];
  assign pkt_id  = pkt_addr[2 + word_addr_width_lp +: block_id_width_lp];

  logic oob;
  if (block_words_lp == (1 << word_addr_width_lp)) begin : g_pow2
    assign oob = 1'b0;
  end else begin : g_npow2
    assign oob = ({1'b0, pkt_idx} >= (word_addr_width_lp + 1)'(block_words_lp));
  end

  logic is_load, is_store, not_nop, accept, drop, load_acc, store_acc;

  assign is_load   = (pkt_op == OpLw) || (pkt_op == OpLb) || (pkt_op == OpLbu) ||
                     (pkt_op == OpLh) || (pkt_op == OpLhu);
  assign is_store  = (pkt_op == OpStore);
  assign not_nop   = (pkt_op != OpNop);
  assign drop      = v_i && not_nop && ((pkt_id != block_id_i) || busy_o || oob);
  assign accept    = v_i && not_nop && !drop;
  assign load_acc  = accept && is_load;
  assign store_acc = accept && is_store;

  logic                          scrub_we;
  logic [word_addr_width_lp-1:0] scrub_q;

`ifdef BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN
  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                        state_q, state_d;
  logic [word_addr_width_lp-1:0] scrub_d;

  always_comb begin
    state_d  = state_q;
    scrub_d  = scrub_q;
    scrub_we = 1'b0;
    unique case (state_q)
      StInit: begin
        scrub_we = 1'b1;
        scrub_d  = scrub_q + word_addr_width_lp'(1);
        if (scrub_q == word_addr_width_lp'(block_words_lp - 1)) begin
          state_d = StReady;
          scrub_d = '0;
        end
      end
      StReady: begin
        state_d = StReady;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StInit;
      scrub_q <= '0;
    end else begin
      state_q <= state_d;
      scrub_q <= scrub_d;
    end
  end

  assign busy_o = (state_q == StInit);
`else
  assign scrub_we = 1'b0;
  assign scrub_q  = '0;
  assign busy_o   = 1'b0;
`endif

  // Storage has no reset; only the response path is cleared.
  logic [data_width_p-1:0] mem_q [block_words_lp];

  always_ff @(posedge clk_i) begin
    if (scrub_we) begin
      mem_q[scrub_q] <= '0;
    end else if (store_acc) begin
      for (int k = 0; k < data_width_p / 8; k++) begin
        if (pkt_mask[k]) mem_q[pkt_idx][8*k +: 8] <= pkt_data[8*k +: 8];
      end
    end
  end

  logic [data_width_p-1:0] rdata_q;
  logic [2:0]              op_q;
  logic [1:0]              off_q;
  logic                    err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdata_q <= '0;
      op_q    <= OpNop;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= drop;
      if (load_acc) begin
        rdata_q <= mem_q[pkt_idx];
        op_q    <= pkt_op;
        off_q   <= pkt_off;
      end
    end
  end

  assign err_o = err_q;

  // Extension depends only on registered state, so data_o is stable through the response cycle.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_q[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    data_o   = rdata_q;
    case (op_q)
      OpLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   data_o = {24'h0, byte_sel};
      OpLh:    data_o = {{16{half_sel[15]}}, half_sel};
      OpLhu:   data_o = {16'h0, half_sel};
      default: data_o = rdata_q;
    endcase
  end

endmodule

// File: tb/tb_bsg_manycore_block_mem_bank.sv
// Self-checking bench for bsg_manycore_block_mem_bank: directed scenarios plus random traffic
// checked against a word-array model of the bank.
module tb_bsg_manycore_block_mem_bank;

  localparam int unsigned MemWords   = 512;
  localparam int unsigned TilesX     = 4;
  localparam int unsigned BlockWords = 64;
  localparam int unsigned PW         = 3 + 11 + 32 + 4;

  localparam logic [2:0] MyId    = 3'd3;
  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpLw    = 3'd1;
  localparam logic [2:0] OpLb    = 3'd2;
  localparam logic [2:0] OpLbu   = 3'd3;
  localparam logic [2:0] OpLh    = 3'd4;
  localparam logic [2:0] OpLhu   = 3'd5;
  localparam logic [2:0] OpStore = 3'd6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] pkt;
  logic          v;
  logic [2:0]    block_id;
  logic [31:0]   data_o;
  logic          err_o;
  logic          busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_mem [BlockWords];
  bit          exp_vld [BlockWords];
  logic [31:0] exp_data;
  logic        exp_err;

  bsg_manycore_block_mem_bank #(
    .data_width_p       (32),
    .mem_size_in_words_p(MemWords),
    .num_tiles_x_p      (TilesX)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .pkt_i     (pkt),
    .v_i       (v),
    .block_id_i(block_id),
    .data_o    (data_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w,
                                             input int off);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      OpLb:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      OpLbu:   return b;
      OpLh:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      OpLhu:   return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset(input bit zeroed);
    exp_data = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < BlockWords; i++) begin
      exp_mem[i] = '0;
      exp_vld[i] = zeroed;
    end
  endtask

  // Drives one packet for one cycle; the model then holds what the DUT should show after the edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] id, input int idx, input int off,
                       input logic [31:0] d, input logic [3:0] m);
    logic [31:0] bm;
    @(negedge clk);
    pkt = {op, id, 6'(idx), 2'(off), d, m};
    v   = 1'b1;
    @(posedge clk);
    #1;
    exp_err = (op != OpNop) && (id != MyId);
    if (op != OpNop && id == MyId) begin
      if (op == OpStore) begin
        bm = '0;
        for (int k = 0; k < 4; k++) if (m[k]) bm = bm | (32'hFF << (8 * k));
        exp_mem[idx] = (exp_mem[idx] & ~bm) | (d & bm);
        if (m == 4'hF) exp_vld[idx] = 1'b1;
      end else if (op >= OpLw && op <= OpLhu) begin
        exp_data = model_load(op, exp_mem[idx], off);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v = 1'b0;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    v       = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: got %h want 00000000", data_o);
    end
    n_checks++;
    if (err_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_err: got %b want 0", err_o);
    end
`ifdef BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_busy: got %b want 1", busy_o);
    end
`else
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b want 0", busy_o);
    end
    reset_n = 1'b1;
    model_reset(1'b0);
    idle();
    n_checks++;
    if (data_o !== 32'h0 || busy_o !== 1'b0) begin
      n_errors++; $display("FAIL post_release: got data %h busy %b want 0 0", data_o, busy_o);
    end
`endif
  endtask

`ifdef BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN
  task automatic test_zero_init();
    int cnt;
    @(negedge clk);
    reset_n = 1'b0;
    v       = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 11) begin
        n_checks++;
        if (err_o !== 1'b1) begin
          n_errors++; $display("FAIL busy_drop_err: got %b want 1", err_o);
        end
        v = 1'b0;
      end
      if (cnt == 10) begin
        pkt = {OpLw, MyId, 6'd3, 2'd0, 32'h0, 4'h0};
        v   = 1'b1;
      end
      @(negedge clk);
      #2;
    end
    n_checks++;
    if (cnt != BlockWords) begin
      n_errors++; $display("FAIL busy_cycles: got %0d want %0d", cnt, BlockWords);
    end
    model_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      issue(OpLw, MyId, $urandom_range(0, BlockWords - 1), 0, 32'h0, 4'h0);
      n_checks++;
      if (data_o !== 32'h0 || err_o !== 1'b0) begin
        n_errors++; $display("FAIL scrubbed_load: got %h err %b want 0 0", data_o, err_o);
      end
    end
  endtask
`endif

  task automatic test_store_load_word();
    issue(OpStore, MyId, 5, 0, 32'hDEAD_BEEF, 4'hF);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_errors++; $display("FAIL store_err: got %b want 0", err_o);
    end
    issue(OpLw, MyId, 5, 0, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL store_load_word: got %h want deadbeef", data_o);
    end
    idle();
    n_checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL load_hold: got %h want deadbeef", data_o);
    end
  endtask

  task automatic test_masked_subword();
    issue(OpStore, MyId, 0, 0, 32'h1122_3344, 4'hF);
    issue(OpStore, MyId, 0, 0, 32'h0000_AA00, 4'b0010);
    issue(OpLw, MyId, 0, 0, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'h1122_AA44) begin
      n_errors++; $display("FAIL masked_lw: got %h want 1122aa44", data_o);
    end
    issue(OpLb, MyId, 0, 1, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'hFFFF_FFAA) begin
      n_errors++; $display("FAIL lb_off1: got %h want ffffffaa", data_o);
    end
    issue(OpLbu, MyId, 0, 1, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'h0000_00AA) begin
      n_errors++; $display("FAIL lbu_off1: got %h want 000000aa", data_o);
    end
    issue(OpLh, MyId, 0, 2, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'h0000_1122) begin
      n_errors++; $display("FAIL lh_off2: got %h want 00001122", data_o);
    end
    issue(OpLhu, MyId, 0, 3, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'h0000_1122) begin
      n_errors++; $display("FAIL lhu_off3: got %h want 00001122", data_o);
    end
  endtask

  task automatic test_amo();
    issue(OpStore, MyId, 7, 0, 32'd5, 4'hF);
    issue(OpLw, MyId, 7, 0, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'd5) begin
      n_errors++; $display("FAIL amo_read: got %h want 00000005", data_o);
    end
    issue(OpStore, MyId, 7, 0, 32'd6, 4'hF);
    n_checks++;
    if (data_o !== 32'd5) begin
      n_errors++; $display("FAIL amo_store_keeps_data: got %h want 00000005", data_o);
    end
    issue(OpLw, MyId, 7, 0, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'd6) begin
      n_errors++; $display("FAIL amo_readback: got %h want 00000006", data_o);
    end
  endtask

  task automatic test_foreign();
    issue(OpStore, 3'd2, 7, 0, 32'h0000_0BAD, 4'hF);
    n_checks++;
    if (err_o !== 1'b1 || data_o !== 32'd6) begin
      n_errors++; $display("FAIL foreign_drop: got err %b data %h want 1 00000006", err_o, data_o);
    end
    issue(OpNop, MyId, 7, 0, 32'h0, 4'h0);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_errors++; $display("FAIL nop_err: got %b want 0", err_o);
    end
    issue(OpLw, MyId, 7, 0, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'd6 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL foreign_unchanged: got %h err %b want 00000006 0", data_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) issue(OpStore, MyId, 10 + i, 0, 32'h0101_0101 * (i + 1), 4'hF);
    for (int i = 0; i < 8; i++) begin
      issue(OpLw, MyId, 10 + i, 0, 32'h0, 4'h0);
      n_checks++;
      if (data_o !== 32'h0101_0101 * (i + 1)) begin
        n_errors++;
        $display("FAIL b2b_load[%0d]: got %h want %h", i, data_o, 32'h0101_0101 * (i + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  ops [8];
    logic [2:0]  op;
    logic [2:0]  id;
    int          idx;
    int          off;
    logic [31:0] d;
    logic [3:0]  m;
    ops = '{OpStore, OpStore, OpLw, OpLb, OpLbu, OpLh, OpLhu, OpNop};
    for (int i = 0; i < 300; i++) begin
      op  = ops[$urandom_range(0, 7)];
      idx = $urandom_range(0, BlockWords - 1);
      off = $urandom_range(0, 3);
      d   = $urandom;
      m   = 4'($urandom);
      id  = ($urandom_range(0, 9) == 0) ? (MyId ^ 3'($urandom_range(1, 7))) : MyId;
      if (op != OpStore && op != OpNop && id == MyId && !exp_vld[idx]) begin
        op = OpStore;
        m  = 4'hF;
      end
      issue(op, id, idx, off, d, m);
      n_checks++;
      if (data_o !== exp_data || err_o !== exp_err) begin
        n_errors++;
        $display("FAIL random[%0d] op %0d w %0d: got %h err %b want %h err %b",
                 i, op, idx, data_o, err_o, exp_data, exp_err);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cnt;
    issue(OpStore, MyId, 9, 0, 32'h1234_5678, 4'hF);
    issue(OpLw, MyId, 9, 0, 32'h0, 4'h0);
    issue(OpStore, 3'd1, 9, 0, 32'h0, 4'hF);
    n_checks++;
    if (data_o !== 32'h1234_5678 || err_o !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset: got %h err %b want 12345678 1", data_o, err_o);
    end
    @(negedge clk);
    pkt = {OpLw, MyId, 6'd9, 2'd0, 32'h0, 4'h0};
    v   = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (data_o !== 32'h0 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL async_reset: got %h err %b want 0 0", data_o, err_o);
    end
    v = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (data_o !== 32'h0 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL no_stale_resp: got %h err %b want 0 0", data_o, err_o);
    end
`ifdef BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++; $display("FAIL rescrub_done: got busy %b want 0", busy_o);
    end
    model_reset(1'b1);
`else
    cnt = 0;
    model_reset(1'b0);
`endif
    issue(OpStore, MyId, 20, 0, 32'hCAFE_F00D, 4'hF);
    issue(OpLh, MyId, 20, 2, 32'h0, 4'h0);
    n_checks++;
    if (data_o !== 32'hFFFF_CAFE) begin
      n_errors++; $display("FAIL post_reset_load: got %h want ffffcafe", data_o);
    end
  endtask

  initial begin
    pkt      = '0;
    v        = 1'b0;
    block_id = MyId;
    reset_n  = 1'b0;
    model_reset(1'b0);
    test_reset();
`ifdef BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN
    test_zero_init();
`endif
    test_store_load_word();
    test_masked_subword();
    test_amo();
    test_foreign();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_block_mem_bank.md
# bsg_manycore_block_mem_bank

- Single-port, synchronous-read memory bank holding one block of the partitioned on-chip block memory.
- Consumes the block-mem packet stream (`pkt_i`/`v_i`) produced by the manycore-link-to-block-mem adapter directly upstream, and returns load data to it one cycle later on `data_o`.
- Performs byte-masked stores, and sign/zero extension for sub-word loads.
- Filters packets that name a different block id.

## Interface

Parameters:
- `data_width_p`, 32: word width; must be 32.
- `mem_size_in_words_p`, none: total block-memory size in words across all banks.
- `num_tiles_x_p`, none: tile columns; the memory splits into 2*`num_tiles_x_p` blocks.
- `mem_addr_width_lp`, derived: `BSG_SAFE_CLOG2`(`mem_size_in_words_p`)+2; byte address width.
- `block_id_width_lp`, derived: `BSG_SAFE_CLOG2`(2*`num_tiles_x_p`).
- `block_words_lp`, derived: `mem_size_in_words_p`/(2*`num_tiles_x_p`).
- `word_addr_width_lp`, derived: `BSG_SAFE_CLOG2`(`block_words_lp`).

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `pkt_i` in `block_mem_pkt_width`(`mem_addr_width_lp`,`data_width_p`): `block_mem_pkt_s` with fields opcode, addr, data, mask.
- `v_i` in 1: packet valid. There is no backpressure; a packet is accepted every valid cycle.
- `block_id_i` in `block_id_width_lp`: this bank's block id; static after reset.
- `data_o` out 32: load result for the packet accepted in the previous cycle.
- `err_o` out 1: one-cycle pulse on a dropped packet.
- `busy_o` out 1: bank is initialising and does not accept packets.

## Operation

- Address decode: addr = {block id, word index[`word_addr_width_lp`-1:0], byte offset[1:0]}.
- A packet is accepted when `v_i` & !`busy_o` & block id == `block_id_i` & opcode != e_nop.
- A packet is dropped, with `err_o`=1 in the next cycle, when `v_i` and any of:
  - block-id mismatch;
  - `busy_o` high;
  - word index >= `block_words_lp`.
- e_nop is ignored silently.
- e_store: writes byte lane k of data where mask[k]=1. Lanes are pre-aligned by upstream. Mask 4'b0000 is a legal no-op write.
- Loads: read the full word at the word index, and latch opcode and byte offset into a one-deep response register.
  - e_lw: word as read.
  - e_lb / e_lbu: byte at offset[1:0], sign- or zero-extended.
  - e_lh / e_lhu: halfword at offset[1]; offset[0] is ignored. Sign- or zero-extended.
- `data_o` holds the last load result. Stores, nops and dropped packets do not change it.
- State machine (`INIT` exists only with the macro):
  - `INIT`: scrubbing; `busy_o`=1. Moves to `READY` after the last word is written.
  - `READY`: normal service.

## Timing

- Reset values: `data_o`=0, `err_o`=0, response register cleared, state `INIT` (macro on) or `READY` (macro off). `busy_o`=1 with macro, 0 without.
- Load accepted at the cycle t edge: `data_o` is valid for the whole of cycle t+1.
  - The value comes from the read register plus combinational extension selected by the registered opcode and offset; it does not depend on cycle t+1 inputs.
  - Upstream depends on this for AMO read-modify-write and for back-to-back ifetch.
- Store accepted at cycle t is visible to a load accepted at cycle t+1 at the same word. No bypass is needed: the write completes at the t edge.
- Back-to-back loads are sustained at 1 per cycle.
- Asynchronous reset asserted mid-operation:
  - discards the pending response and the scrub progress;
  - memory contents are not guaranteed;
  - with the macro, scrub restarts from word 0 after release.
- `err_o` is registered: it pulses in cycle t+1 for a drop at t.

## Configuration

- Macro: `BSG_MANYCORE_BLOCK_MEM_BANK_ZERO_INIT_EN`.
- Defined:
  - After reset release, a counter writes 0 to words 0..`block_words_lp`-1, one per cycle.
  - `busy_o` deasserts in the cycle after the final write, exactly `block_words_lp` cycles after release.
  - Loads after that return 0 for unwritten words.
- Undefined: there is no `INIT` state, `busy_o` is tied 0, and contents after reset are undefined (X in simulation).

## Test plan

- **Store/load word:** block_id_i=3; e_store addr word 5, data 0xDEADBEEF, mask 4'b1111; next cycle e_lw word 5 -> `data_o`=0xDEADBEEF in the following cycle.
- **Masked store and sub-word loads:** word 0 = 0x11223344; e_store data 0x0000AA00, mask 4'b0010; then read back:
  - e_lw -> 0x1122AA44;
  - e_lb offset 1 -> 0xFFFFFFAA;
  - e_lbu offset 1 -> 0x000000AA;
  - e_lh offset 2 -> 0x00001122.
- **AMO-style read then write:** e_lw word 7 (holding 5), then e_store word 7 data 6 in the next cycle -> `data_o`=5 during the store cycle; a later e_lw word 7 -> 6.
- **Foreign block and hold:**
  - packet with block id 2 into bank 3 -> `err_o` pulses one cycle, memory unchanged, `data_o` keeps its previous value;
  - a nop -> no `err_o`.
- **Reset mid-stream:** assert `reset_n_i` low between a load and its response cycle -> `data_o`=0 and `err_o`=0 immediately; no stale response after release.
- **ZERO_INIT_EN:** with `block_words_lp`=64:
  - `busy_o` is high for exactly 64 cycles after release;
  - a load during busy -> `err_o`;
  - afterwards e_lw of any word -> 0.
